// File: rtl/scan_decoder_pkg.sv
// Shared types, constants and the one-hot helper for the scan decoder.
package dec_pkg;

    localparam int unsigned STATE_W      = 2;
    localparam int unsigned ONEHOT_MAX_W = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // One-hot of idx; all zeros when idx is not a legal line for out_w lines.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                       input int unsigned out_w);
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        if ((idx < out_w) && (idx < ONEHOT_MAX_W)) begin
            v = ONEHOT_MAX_W'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_decoder_dwell_timer.sv
// Dwell timer: tick marks the last of every DWELL consecutive run cycles.
module dwell_timer #(
    parameter int unsigned DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned      CNT_W    = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;

    // clr has priority so a restart never produces a stray tick
    assign tick = run && !clr && (cnt_q == CNT_LAST);

    // Count run cycles, folding back to zero on each tick
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with DIRECT decode and auto-stepping SCAN mode.
module scan_decoder
    import dec_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned OUT_W = 2 ** SEL_W,
    parameter int unsigned DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             mode,
    input  logic             load,
    input  logic [SEL_W-1:0] data_in,
    output logic [OUT_W-1:0] data_out,
    output logic [SEL_W-1:0] idx_out,
    output logic             valid,
    output logic             wrap
);

    state_e           state_q;
    state_e           state_d;
    logic [OUT_W-1:0] data_out_d;
    logic [SEL_W-1:0] idx_d;
    logic             valid_d;
    logic             wrap_d;

    logic din_ok;
    logic idx_last;
    logic stay_scan;
    logic load_ok;
    logic timer_clr;
    logic tick;

    assign din_ok    = 32'(data_in) < OUT_W;
    assign idx_last  = 32'(idx_out) == (OUT_W - 1);
    // Only a cycle that stays in SCAN counts dwell or accepts a load
    assign stay_scan = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    assign load_ok   = stay_scan && load && din_ok;
    assign timer_clr = !stay_scan || load_ok;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .run  (stay_scan),
        .tick (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ena=0 always returns to IDLE, otherwise mode picks the state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ena) begin
                    state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
                end
            end
            ST_DIRECT: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (mode == MODE_SCAN) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (mode == MODE_DIRECT) begin
                    state_d = ST_DIRECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; SCAN entry restarts at index 0
    always_comb begin
        data_out_d = '0;
        idx_d      = '0;
        valid_d    = 1'b0;
        wrap_d     = 1'b0;
        unique case (state_d)
            ST_DIRECT: begin
                idx_d = data_in;
                if (din_ok) begin
                    data_out_d = OUT_W'(onehot(32'(data_in), OUT_W));
                    valid_d    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!stay_scan) begin
                    idx_d = '0;
                end else if (load_ok) begin
                    idx_d = data_in;
                end else if (tick) begin
                    if (idx_last) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_out + SEL_W'(1);
                    end
                end else begin
                    idx_d = idx_out;
                end
                data_out_d = OUT_W'(onehot(32'(idx_d), OUT_W));
                valid_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers; idx_out doubles as the scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            idx_out  <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            data_out <= data_out_d;
            idx_out  <= idx_d;
            valid    <= valid_d;
            wrap     <= wrap_d;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench: instance A (8 lines, DWELL=2) and instance B (6 lines, DWELL=1).
module tb_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_ena, a_mode, a_load;
    logic [2:0] a_din;
    logic [7:0] a_dout;
    logic [2:0] a_idx;
    logic       a_valid, a_wrap;

    logic       b_rst, b_ena, b_mode, b_load;
    logic [2:0] b_din;
    logic [5:0] b_dout;
    logic [2:0] b_idx;
    logic       b_valid, b_wrap;

    scan_decoder #(.SEL_W(3), .OUT_W(8), .DWELL(2)) u_dut_a (
        .clk      (clk),
        .rst      (a_rst),
        .ena      (a_ena),
        .mode     (a_mode),
        .load     (a_load),
        .data_in  (a_din),
        .data_out (a_dout),
        .idx_out  (a_idx),
        .valid    (a_valid),
        .wrap     (a_wrap)
    );

    scan_decoder #(.SEL_W(3), .OUT_W(6), .DWELL(1)) u_dut_b (
        .clk      (clk),
        .rst      (b_rst),
        .ena      (b_ena),
        .mode     (b_mode),
        .load     (b_load),
        .data_in  (b_din),
        .data_out (b_dout),
        .idx_out  (b_idx),
        .valid    (b_valid),
        .wrap     (b_wrap)
    );

    typedef struct {
        bit         sel_b;
        logic [7:0] dout;
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic logic [7:0] oh(input int i);
        return 8'(1) << i;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the next edge
    task automatic cyc(input bit sel_b, input logic rst, ena, mode, load,
                       input logic [2:0] din, input string nm,
                       input logic [7:0] dout, input logic [2:0] idx,
                       input logic valid, wrap);
        exp_t e;
        @(negedge clk);
        if (sel_b) begin
            b_rst = rst; b_ena = ena; b_mode = mode; b_load = load; b_din = din;
        end else begin
            a_rst = rst; a_ena = ena; a_mode = mode; a_load = load; a_din = din;
        end
        e.sel_b = sel_b;
        e.dout  = dout;
        e.idx   = idx;
        e.valid = valid;
        e.wrap  = wrap;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: after each edge, pop one expectation and compare the selected instance
    always @(posedge clk) begin : monitor
        exp_t       e;
        string      nm;
        logic [7:0] gd;
        logic [2:0] gi;
        logic       gv, gw;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.sel_b) begin
                gd = {2'b00, b_dout}; gi = b_idx; gv = b_valid; gw = b_wrap;
            end else begin
                gd = a_dout; gi = a_idx; gv = a_valid; gw = a_wrap;
            end
            n_vec++;
            if ({gd, gi, gv, gw} !== {e.dout, e.idx, e.valid, e.wrap}) begin
                n_err++;
                $display("FAIL %s: got data_out=%02h idx_out=%0d valid=%b wrap=%b, want data_out=%02h idx_out=%0d valid=%b wrap=%b",
                         nm, gd, gi, gv, gw, e.dout, e.idx, e.valid, e.wrap);
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_ena = 1'b0; a_mode = 1'b0; a_load = 1'b0; a_din = 3'd0;
        b_rst = 1'b1; b_ena = 1'b0; b_mode = 1'b0; b_load = 1'b0; b_din = 3'd0;

        // Instance A: reset and DIRECT sweep
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "a_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        for (int d = 0; d < 8; d++) begin
            for (int k = 0; k < 10; k++) begin
                cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(d), "direct", oh(d), 3'(d), 1'b1, 1'b0);
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, "direct_load_ignored", 8'h08, 3'd3, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, "direct_ena_off", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "idle_hold", 8'h00, 3'd0, 1'b0, 1'b0);

        // SCAN from IDLE with DWELL=2: each index twice, wrap every 16 cycles
        for (int c = 0; c < 37; c++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "scan_dwell2", oh((c / 2) % 8),
                3'((c / 2) % 8), 1'b1, (c > 0) && (c % 16 == 0));
        end

        // Load 5 while showing idx 2, then step, then load colliding with a wrap
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, "load5", oh(5), 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "load5_hold", oh(5), 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "load_step6", oh(6), 3'd6, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "hold6", oh(6), 3'd6, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "step7", oh(7), 3'd7, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "hold7", oh(7), 3'd7, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, "load_beats_wrap", oh(3), 3'd3, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "hold3", oh(3), 3'd3, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "step4", oh(4), 3'd4, 1'b1, 1'b0);

        // ena=0 at idx 4 beats a pending load; re-entry restarts at 0
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, "ena_off_over_load", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "idle", 8'h00, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "scan_reentry", oh(c / 2), 3'(c / 2), 1'b1, 1'b0);
        end

        // rst with load at idx 3: everything cleared, load discarded
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, "rst_over_load", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, "post_rst_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "scan_entry", oh(0), 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, "scan_to_direct", oh(6), 3'd6, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6, "direct_to_scan", oh(0), 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "a_park", 8'h00, 3'd0, 1'b0, 1'b0);

        // Instance B: 6 lines, DWELL=1
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "b_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, "b_direct_6", 8'h00, 3'd6, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, "b_direct_7", 8'h00, 3'd7, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, "b_direct_5", 8'h20, 3'd5, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "b_scan", oh(c % 6), 3'(c % 6), 1'b1,
                (c > 0) && (c % 6 == 0));
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, "b_load_7_ignored", oh(2), 3'd2, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, "b_load_6_ignored", oh(3), 3'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, "b_load_4", oh(4), 3'd4, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "b_step5", oh(5), 3'd5, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "b_wrap", oh(0), 3'd0, 1'b1, 1'b1);

        // Let the monitor consume the last expectation
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
